ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline register and branch-resolution stage directly downstream of the 8-bit ALU in the pipelined CPU.
- Captures the ALU result, zero and carry outputs together with the instruction control fields.
- Maintains architectural Z/C flags, resolves conditional branches and drives the memory stage.
- Kills the single wrong-path instruction that enters behind a taken branch.

Parameters:
- DW, 8, data/address width (matches ALU).
- RW, 3, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction present from the execute stage.
- in_func  in  4  ALU function code of the instruction.
- in_result  in  DW  ALU result; this is the address for LOAD and STORE.
- in_z  in  1  ALU zero output.
- in_carry  in  1  ALU carry/borrow output.
- in_rd  in  RW  destination register.
- in_store_data  in  DW  store operand.
- in_pc  in  DW  instruction PC.
- in_br_off  in  DW  branch offset, two's complement.
- stall  in  1  downstream stall; hold the stage.
- flush  in  1  external kill of the instruction being captured.
- in_ready  out  1  equals ~stall (combinational).
- out_valid  out  1  stage holds a live instruction.
- out_func  out  4  registered function code.
- out_result  out  DW  registered result/address.
- out_rd  out  RW  registered destination.
- out_store_data  out  DW  registered store data.
- out_we  out  1  register-file write enable.
- out_mem_rd  out  1  memory read request (LOAD).
- out_mem_wr  out  1  memory write request (STORE).
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry flag.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  DW  redirect PC, valid while br_taken=1.

Behaviour:
- Reset (async, rst=1): all outputs except in_ready are 0. The internal shadow_kill bit is 0.
- Function codes:
  - 0001 ADD, 0010 SUB, 0011 INC, 0100 DEC, 0101 ADDI, 0110 SUBI, 0111 XOR, 1000 NOT.
  - 1001 BEQ, 1010 BNE, 1011 BLT, 1100 BGT, 1110 LOAD, 1111 STORE.
  - 0000 and 1101 are NOP.
- Capture condition: cap = in_valid & ~stall & ~flush & ~shadow_kill.
- Per-edge priority: rst > stall > flush/shadow_kill > capture.
- Stall:
  - All registers hold, including flags and shadow_kill.
  - br_taken is forced to 0 on the next edge, so the pulse never repeats.
  - in_valid is ignored.
- Not stalled and not cap: out_valid=0, out_we, out_mem_rd, out_mem_wr and br_taken all 0. Data registers may hold their previous values.
- cap:
  - out_valid=1; out_func, out_result, out_rd and out_store_data are loaded.
  - out_we=1 for func 0001–1000 and 1110, otherwise 0.
  - out_mem_rd=(func==1110); out_mem_wr=(func==1111).
- Flags, updated only on cap:
  - func 0001–0100: flag_z=in_z and flag_c=in_carry.
  - func 0101–1000: flag_z=in_z; flag_c is unchanged.
  - All other funcs leave both flags unchanged.
- Branch, evaluated only on cap:
  - BEQ is taken when in_z=1.
  - BNE is taken when in_z=0.
  - BLT is taken when in_carry=1 (borrow of a−b).
  - BGT is taken when in_carry=1 (borrow of b−a).
  - If taken: br_taken=1 on the next edge; br_target = in_pc + in_br_off, mod 2^DW.
  - If not taken: br_taken=0.
  - A branch is captured with out_valid=1 and out_we=0.
- Shadow kill:
  - shadow_kill is set on the edge where br_taken is set.
  - It is cleared on the next non-stalled edge.
  - While shadow_kill=1, the instruction presented is dropped (treated as not cap).
  - Net effect: exactly one instruction behind a taken branch is discarded.
- Latency: 1 cycle from capture to outputs; br_taken is a 1-cycle pulse.
- Reset mid-operation: all outputs clear immediately, asynchronously, including a pending br_taken and shadow_kill.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 and br_taken=1 -> all outputs 0 immediately, before the next clk edge.
- ADD capture: func=0001, result=0x00, z=1, carry=1, rd=3 -> next cycle out_valid=1, out_we=1, out_rd=3, flag_z=1, flag_c=1.
- XOR after ADD: func=0111, z=0 -> flag_z=0, flag_c stays 1.
- BEQ taken: func=1001, z=1, pc=0xF0, off=0x20 -> br_taken=1 for exactly one cycle, br_target=0x10 (wrap).
  - A following in_valid ADD is dropped (out_valid=0).
  - The instruction after that ADD is captured.
- BLT/BNE not taken: BLT with carry=0, then BNE with z=1 -> br_taken stays 0, out_we=0, flags unchanged.
- Stall and flush:
  - LOAD, result=0x44, captured then stall held 3 cycles -> outputs frozen with out_mem_rd=1.
  - Branch captured then stalled -> br_taken high for only the first cycle.
  - flush with in_valid=1 STORE -> out_valid=0, out_mem_wr=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU outputs and control fields, keeps the
// architectural Z/C flags, resolves conditional branches and drops the wrong-path slot.
module ex_mem_stage #(
   parameter int DW = 8,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [3:0]    in_func,
   input  logic [DW-1:0] in_result,
   input  logic          in_z,
   input  logic          in_carry,
   input  logic [RW-1:0] in_rd,
   input  logic [DW-1:0] in_store_data,
   input  logic [DW-1:0] in_pc,
   input  logic [DW-1:0] in_br_off,
   input  logic          stall,
   input  logic          flush,
   output logic          in_ready,
   output logic          out_valid,
   output logic [3:0]    out_func,
   output logic [DW-1:0] out_result,
   output logic [RW-1:0] out_rd,
   output logic [DW-1:0] out_store_data,
   output logic          out_we,
   output logic          out_mem_rd,
   output logic          out_mem_wr,
   output logic          flag_z,
   output logic          flag_c,
   output logic          br_taken,
   output logic [DW-1:0] br_target
);

   localparam logic [3:0] F_BEQ   = 4'b1001;
   localparam logic [3:0] F_BNE   = 4'b1010;
   localparam logic [3:0] F_BLT   = 4'b1011;
   localparam logic [3:0] F_BGT   = 4'b1100;
   localparam logic [3:0] F_LOAD  = 4'b1110;
   localparam logic [3:0] F_STORE = 4'b1111;

   logic          shadow_kill;
   logic          cap;
   logic          cond;
   logic          taken;
   logic          is_write;
   logic          sets_zc;
   logic          sets_z;
   logic [DW-1:0] target;

   assign in_ready = ~stall;

   always_comb begin
      cap      = in_valid & ~stall & ~flush & ~shadow_kill;
      cond     = 1'b0;
      case (in_func)
         F_BEQ:        cond = in_z;
         F_BNE:        cond = ~in_z;
         F_BLT, F_BGT: cond = in_carry;
         default:      cond = 1'b0;
      endcase
      taken    = cap & cond;
      sets_zc  = (in_func >= 4'd1) && (in_func <= 4'd4);
      sets_z   = (in_func >= 4'd5) && (in_func <= 4'd8);
      is_write = sets_zc || sets_z || (in_func == F_LOAD);
      target   = in_pc + in_br_off;
   end

   // A stall freezes everything except the redirect pulse, which must not repeat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_func       <= '0;
         out_result     <= '0;
         out_rd         <= '0;
         out_store_data <= '0;
         out_we         <= 1'b0;
         out_mem_rd     <= 1'b0;
         out_mem_wr     <= 1'b0;
         flag_z         <= 1'b0;
         flag_c         <= 1'b0;
         br_taken       <= 1'b0;
         br_target      <= '0;
         shadow_kill    <= 1'b0;
      end else if (stall) begin
         br_taken <= 1'b0;
      end else begin
         out_valid   <= cap;
         out_we      <= cap & is_write;
         out_mem_rd  <= cap & (in_func == F_LOAD);
         out_mem_wr  <= cap & (in_func == F_STORE);
         br_taken    <= taken;
         shadow_kill <= taken;
         if (cap) begin
            out_func       <= in_func;
            out_result     <= in_result;
            out_rd         <= in_rd;
            out_store_data <= in_store_data;
            if (sets_zc || sets_z) begin
               flag_z <= in_z;
            end
            if (sets_zc) begin
               flag_c <= in_carry;
            end
         end
         if (taken) begin
            br_target <= target;
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed literal checks plus a randomized
// run compared every cycle against a behavioural model of the stage.
module tb_ex_mem_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_func;
   logic [7:0] in_result;
   logic       in_z;
   logic       in_carry;
   logic [2:0] in_rd;
   logic [7:0] in_store_data;
   logic [7:0] in_pc;
   logic [7:0] in_br_off;
   logic       stall;
   logic       flush;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_func;
   logic [7:0] out_result;
   logic [2:0] out_rd;
   logic [7:0] out_store_data;
   logic       out_we;
   logic       out_mem_rd;
   logic       out_mem_wr;
   logic       flag_z;
   logic       flag_c;
   logic       br_taken;
   logic [7:0] br_target;

   int checks_total = 0;
   int checks_passed = 0;
   bit checking = 1'b0;

   ex_mem_stage #(.DW(8), .RW(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_func(in_func),
      .in_result(in_result), .in_z(in_z), .in_carry(in_carry), .in_rd(in_rd),
      .in_store_data(in_store_data), .in_pc(in_pc), .in_br_off(in_br_off),
      .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
      .out_func(out_func), .out_result(out_result), .out_rd(out_rd),
      .out_store_data(out_store_data), .out_we(out_we), .out_mem_rd(out_mem_rd),
      .out_mem_wr(out_mem_wr), .flag_z(flag_z), .flag_c(flag_c),
      .br_taken(br_taken), .br_target(br_target)
   );

   always #5 clk = ~clk;

   // Behavioural model: what the stage should present after each edge.
   bit       m_valid, m_we, m_mrd, m_mwr, m_z, m_c, m_bt, m_kill;
   bit [3:0] m_func;
   bit [7:0] m_res, m_sd, m_tgt;
   bit [2:0] m_rd;
   bit       m_cap, m_take;
   int       fcode;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0; m_z = 0; m_c = 0;
         m_bt = 0; m_kill = 0; m_func = 0; m_res = 0; m_sd = 0; m_tgt = 0; m_rd = 0;
      end else if (stall) begin
         m_bt = 0;
      end else begin
         fcode = int'(in_func);
         m_cap = in_valid && !flush && !m_kill;
         m_take = 0;
         m_valid = m_cap;
         m_we = m_cap && ((fcode >= 1 && fcode <= 8) || fcode == 14);
         m_mrd = m_cap && fcode == 14;
         m_mwr = m_cap && fcode == 15;
         if (m_cap) begin
            m_func = in_func; m_res = in_result; m_rd = in_rd; m_sd = in_store_data;
            if (fcode >= 1 && fcode <= 8) m_z = in_z;
            if (fcode >= 1 && fcode <= 4) m_c = in_carry;
            if (fcode == 9)  m_take = in_z;
            if (fcode == 10) m_take = !in_z;
            if (fcode == 11 || fcode == 12) m_take = in_carry;
            if (m_take) m_tgt = 8'((int'(in_pc) + int'(in_br_off)) % 256);
         end
         m_bt = m_take;
         m_kill = m_take;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] f, input logic [7:0] res,
                                input logic z, input logic c, input logic [2:0] rd,
                                input logic [7:0] pc, input logic [7:0] off,
                                input logic st, input logic fl);
      @(negedge clk);
      in_valid = v; in_func = f; in_result = res; in_z = z; in_carry = c; in_rd = rd;
      in_store_data = 8'($urandom_range(255, 0)); in_pc = pc; in_br_off = off;
      stall = st; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_func"}, 32'(out_func), 32'd0);
      checkOutput({tag, "_result"}, 32'(out_result), 32'd0);
      checkOutput({tag, "_rd"}, 32'(out_rd), 32'd0);
      checkOutput({tag, "_sd"}, 32'(out_store_data), 32'd0);
      checkOutput({tag, "_we"}, 32'(out_we), 32'd0);
      checkOutput({tag, "_mrd"}, 32'(out_mem_rd), 32'd0);
      checkOutput({tag, "_mwr"}, 32'(out_mem_wr), 32'd0);
      checkOutput({tag, "_fz"}, 32'(flag_z), 32'd0);
      checkOutput({tag, "_fc"}, 32'(flag_c), 32'd0);
      checkOutput({tag, "_bt"}, 32'(br_taken), 32'd0);
      checkOutput({tag, "_btgt"}, 32'(br_target), 32'd0);
   endtask

   // Cycle-by-cycle comparison against the model once reset has been released.
   always @(posedge clk) begin
      #1;
      if (checking && !rst) begin
         checkOutput("m_valid", 32'(out_valid), 32'(m_valid));
         checkOutput("m_we", 32'(out_we), 32'(m_we));
         checkOutput("m_mem_rd", 32'(out_mem_rd), 32'(m_mrd));
         checkOutput("m_mem_wr", 32'(out_mem_wr), 32'(m_mwr));
         checkOutput("m_flag_z", 32'(flag_z), 32'(m_z));
         checkOutput("m_flag_c", 32'(flag_c), 32'(m_c));
         checkOutput("m_br_taken", 32'(br_taken), 32'(m_bt));
         checkOutput("m_in_ready", 32'(in_ready), 32'(!stall));
         if (m_valid) begin
            checkOutput("m_func", 32'(out_func), 32'(m_func));
            checkOutput("m_result", 32'(out_result), 32'(m_res));
            checkOutput("m_rd", 32'(out_rd), 32'(m_rd));
            checkOutput("m_store_data", 32'(out_store_data), 32'(m_sd));
         end
         if (m_bt) checkOutput("m_br_target", 32'(br_target), 32'(m_tgt));
      end
   end

   initial begin
      rst = 1'b1; in_valid = 0; in_func = 0; in_result = 0; in_z = 0; in_carry = 0;
      in_rd = 0; in_store_data = 0; in_pc = 0; in_br_off = 0; stall = 0; flush = 0;
      repeat (2) @(posedge clk);
      #2;
      checkAllZero("reset");
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;

      applyStimulus(1, 4'h1, 8'h00, 1, 1, 3'd3, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("add_valid", 32'(out_valid), 32'd1);
      checkOutput("add_we", 32'(out_we), 32'd1);
      checkOutput("add_rd", 32'(out_rd), 32'd3);
      checkOutput("add_fz", 32'(flag_z), 32'd1);
      checkOutput("add_fc", 32'(flag_c), 32'd1);

      applyStimulus(1, 4'h7, 8'h5A, 0, 0, 3'd1, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("xor_fz", 32'(flag_z), 32'd0);
      checkOutput("xor_fc", 32'(flag_c), 32'd1);

      applyStimulus(1, 4'h9, 8'h00, 1, 0, 3'd0, 8'hF0, 8'h20, 0, 0);
      step();
      checkOutput("beq_bt", 32'(br_taken), 32'd1);
      checkOutput("beq_target", 32'(br_target), 32'h10);
      checkOutput("beq_valid", 32'(out_valid), 32'd1);
      checkOutput("beq_we", 32'(out_we), 32'd0);
      applyStimulus(1, 4'h1, 8'h11, 0, 0, 3'd4, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("shadow_bt", 32'(br_taken), 32'd0);
      checkOutput("shadow_valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 4'h2, 8'h00, 1, 1, 3'd5, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("after_valid", 32'(out_valid), 32'd1);
      checkOutput("after_rd", 32'(out_rd), 32'd5);
      checkOutput("after_fc", 32'(flag_c), 32'd1);

      applyStimulus(1, 4'hB, 8'h00, 0, 0, 3'd0, 8'h30, 8'h04, 0, 0);
      step();
      checkOutput("blt_bt", 32'(br_taken), 32'd0);
      checkOutput("blt_we", 32'(out_we), 32'd0);
      checkOutput("blt_fz", 32'(flag_z), 32'd1);
      applyStimulus(1, 4'hA, 8'h00, 1, 0, 3'd0, 8'h30, 8'h04, 0, 0);
      step();
      checkOutput("bne_bt", 32'(br_taken), 32'd0);
      checkOutput("bne_valid", 32'(out_valid), 32'd1);
      checkOutput("bne_fc", 32'(flag_c), 32'd1);

      applyStimulus(1, 4'hE, 8'h44, 0, 0, 3'd2, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("load_mrd", 32'(out_mem_rd), 32'd1);
      checkOutput("load_we", 32'(out_we), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 4'hF, 8'h99, 1, 0, 3'd7, 8'h00, 8'h00, 1, 0);
         step();
         checkOutput("stall_mrd", 32'(out_mem_rd), 32'd1);
         checkOutput("stall_result", 32'(out_result), 32'h44);
         checkOutput("stall_ready", 32'(in_ready), 32'd0);
      end

      applyStimulus(1, 4'hA, 8'h00, 0, 0, 3'd0, 8'h10, 8'hFC, 0, 0);
      step();
      checkOutput("bne2_bt", 32'(br_taken), 32'd1);
      checkOutput("bne2_target", 32'(br_target), 32'h0C);
      applyStimulus(1, 4'h1, 8'h00, 0, 0, 3'd1, 8'h00, 8'h00, 1, 0);
      step();
      checkOutput("brstall_bt", 32'(br_taken), 32'd0);
      checkOutput("brstall_valid", 32'(out_valid), 32'd1);
      applyStimulus(1, 4'h1, 8'h00, 0, 0, 3'd1, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("brstall_kill", 32'(out_valid), 32'd0);
      applyStimulus(1, 4'h1, 8'h00, 0, 0, 3'd6, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("brstall_next", 32'(out_valid), 32'd1);
      checkOutput("brstall_rd", 32'(out_rd), 32'd6);

      applyStimulus(1, 4'hF, 8'h21, 0, 0, 3'd0, 8'h00, 8'h00, 0, 1);
      step();
      checkOutput("flush_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_mwr", 32'(out_mem_wr), 32'd0);
      applyStimulus(1, 4'hF, 8'h21, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0);
      step();
      checkOutput("store_mwr", 32'(out_mem_wr), 32'd1);
      checkOutput("store_we", 32'(out_we), 32'd0);

      applyStimulus(1, 4'hC, 8'h00, 0, 1, 3'd0, 8'h80, 8'h01, 0, 0);
      step();
      checkOutput("prerst_bt", 32'(br_taken), 32'd1);
      in_valid = 0;
      #1 rst = 1'b1;
      #1 checkAllZero("midrst");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom_range(9, 0) < 8), 4'($urandom_range(15, 0)),
                       8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)),
                       1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                       8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                       ($urandom_range(4, 0) == 0), ($urandom_range(9, 0) == 0));
      end
      applyStimulus(0, 4'h0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0);
      step();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
